// File: rtl/arbitro_vc_destino.sv
// VC0/VC1 to D0/D1 arbiter: weighted VC0 priority, almost-full backpressure,
// registered push/data one cycle after the pop, per-destination counters.
module arbitro_vc_destino #(
  parameter int DATA_WIDTH = 6,
  parameter int DEST_BIT   = 4,
  parameter int VC0_WEIGHT = 3,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  VC0_empty,
  input  logic                  VC1_empty,
  input  logic [DATA_WIDTH-1:0] VC0_data,
  input  logic [DATA_WIDTH-1:0] VC1_data,
  input  logic                  D0_almost_full,
  input  logic                  D1_almost_full,
  output logic                  VC0_pop,
  output logic                  VC1_pop,
  output logic                  D0_push,
  output logic                  D1_push,
  output logic [DATA_WIDTH-1:0] D0_data_out,
  output logic [DATA_WIDTH-1:0] D1_data_out,
  output logic [1:0]            estado,
  output logic                  idle,
  output logic [CNT_WIDTH-1:0]  contador_D0,
  output logic [CNT_WIDTH-1:0]  contador_D1
);

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_IDLE    = 2'd1,
    S_ACTIVE  = 2'd2,
    S_BLOCKED = 2'd3
  } state_t;

  localparam logic [3:0] WMAX = 4'(VC0_WEIGHT);

  state_t st, nxt;
  logic [3:0] wcnt;

  logic ne0, ne1, dst0, dst1, blk0, blk1;
  logic pref0, pref1, g0, g1, pop, sel_dst;
  logic [DATA_WIDTH-1:0] sel_data;

  assign ne0  = !VC0_empty;
  assign ne1  = !VC1_empty;
  assign dst0 = VC0_data[DEST_BIT];
  assign dst1 = VC1_data[DEST_BIT];
  assign blk0 = dst0 ? D1_almost_full : D0_almost_full;
  assign blk1 = dst1 ? D1_almost_full : D0_almost_full;

  assign pref0 = ne0 && !((wcnt == WMAX) && ne1);
  assign pref1 = !pref0 && ne1;

  // Preferred VC first; the other VC is a fallback when the preferred head is blocked.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!reset) begin
      if (pref0 && !blk0)
        g0 = 1'b1;
      else if (pref1 && !blk1)
        g1 = 1'b1;
      else if (pref0 && ne1 && !blk1)
        g1 = 1'b1;
      else if (pref1 && ne0 && !blk0)
        g0 = 1'b1;
    end
  end

  assign VC0_pop  = g0;
  assign VC1_pop  = g1;
  assign pop      = g0 || g1;
  assign sel_dst  = g0 ? dst0 : dst1;
  assign sel_data = g0 ? VC0_data : VC1_data;

  always_comb begin
    nxt = S_BLOCKED;
    if (!ne0 && !ne1)
      nxt = S_IDLE;
    else if (pop)
      nxt = S_ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      D0_push     <= 1'b0;
      D1_push     <= 1'b0;
      D0_data_out <= '0;
      D1_data_out <= '0;
      contador_D0 <= '0;
      contador_D1 <= '0;
      wcnt        <= '0;
      st          <= S_RESET;
      idle        <= 1'b0;
    end else begin
      D0_push <= pop && !sel_dst;
      D1_push <= pop && sel_dst;
      if (pop && !sel_dst)
        D0_data_out <= sel_data;
      if (pop && sel_dst)
        D1_data_out <= sel_data;
      if (D0_push)
        contador_D0 <= contador_D0 + CNT_WIDTH'(1);
      if (D1_push)
        contador_D1 <= contador_D1 + CNT_WIDTH'(1);
      if (g1 || !ne1)
        wcnt <= '0;
      else if (g0 && wcnt != WMAX)
        wcnt <= wcnt + 4'd1;
      st   <= nxt;
      idle <= (nxt == S_IDLE);
    end
  end

  assign estado = st;

endmodule

// File: doc/arbitro_vc_destino.md
Name: arbitro_vc_destino

Overview:
- Arbiter between the two virtual-channel source FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the transmission path.
- Each cycle it pops at most one word from one VC FIFO.
- The word's destination bit routes it to D0 or D1. The push and data to that FIFO are registered, so they appear one cycle after the pop.
- Arbitration is weighted priority favouring VC0, with almost-full backpressure from the destinations.

Parameters:
- DATA_WIDTH, 6: word width.
- DEST_BIT, 4: bit index selecting the destination; 0 selects D0, 1 selects D1.
- VC0_WEIGHT, 3: maximum consecutive VC0 grants while VC1 is non-empty. Range 1..15.
- CNT_WIDTH, 8: width of the per-destination word counters.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- VC0_empty  in  1  VC0 FIFO empty.
- VC1_empty  in  1  VC1 FIFO empty.
- VC0_data  in  DATA_WIDTH  VC0 head word. Show-ahead: valid whenever VC0_empty=0.
- VC1_data  in  DATA_WIDTH  VC1 head word, same rule as VC0_data.
- D0_almost_full  in  1  D0 FIFO cannot accept the pipeline's worth of words.
- D1_almost_full  in  1  same, for D1.
- VC0_pop  out  1  combinational pop to VC0.
- VC1_pop  out  1  combinational pop to VC1.
- D0_push  out  1  registered push to D0.
- D1_push  out  1  registered push to D1.
- D0_data_out  out  DATA_WIDTH  registered data to D0.
- D1_data_out  out  DATA_WIDTH  registered data to D1.
- estado  out  2  FSM state: RESET=0, IDLE=1, ACTIVE=2, BLOCKED=3.
- idle  out  1  high when estado==IDLE.
- contador_D0  out  CNT_WIDTH  words pushed to D0.
- contador_D1  out  CNT_WIDTH  words pushed to D1.

Behaviour:
- Reset values (reset=1 at a clk edge):
  - D0_push = D1_push = 0; D0_data_out = D1_data_out = 0.
  - contador_D0 = contador_D1 = 0; weight counter wcnt = 0.
  - estado = RESET; idle = 0.
  - VC0_pop and VC1_pop are forced to 0 combinationally while reset=1.
- Destination of a VCx head word: dX = VCx_data[DEST_BIT]. The head is blocked if D(dX)_almost_full=1.
- Candidate selection (combinational):
  - Preferred VC is VC0 if VC0 is non-empty and not (wcnt==VC0_WEIGHT and VC1 non-empty). Otherwise VC1 if VC1 is non-empty.
  - Grant the preferred VC if its head is not blocked.
  - Otherwise grant the other VC if it is non-empty and its head is not blocked. This is a fallback; there is no head-of-line stall across VCs.
  - Otherwise no grant.
- At most one pop per cycle; VC0_pop and VC1_pop are never both 1.
- Latency: a pop in cycle N produces push=1 on exactly one of D0/D1 in cycle N+1, with data_out equal to the popped word unmodified.
  - The non-selected destination's push is 0.
  - Each data_out holds its last value when its push is 0.
- Destination FIFOs must assert almost_full with at least 2 free entries to absorb the one in-flight word.
- wcnt updates at each clk edge, reset=0:
  - VC1 granted, or VC1 empty: wcnt <= 0.
  - Else, VC0 granted: wcnt <= wcnt+1, saturating at VC0_WEIGHT.
  - Else: hold.
- Counters: contador_Dx increments by 1 in the cycle after each Dx push is registered, i.e. it tracks asserted pushes. It wraps modulo 2^CNT_WIDTH.
- FSM (registered, next state evaluated each non-reset edge):
  - Any state goes to RESET on reset.
  - Otherwise go to IDLE if both VCs are empty, ACTIVE if a pop occurred this cycle, or BLOCKED if some VC is non-empty but no pop occurred.
  - RESET exits on the first edge with reset=0.
- Reset mid-operation: pops are gated the same cycle. The push registered for an in-flight word is cleared at the reset edge and that word is discarded; no push is emitted for it.
- Both almost_full flags high: no pops, estado=BLOCKED; resumes on the first cycle either flag drops.

Test Plan:
- Reset: hold reset 2 cycles with both VCs non-empty -> pops=0, pushes=0, data_out=0, estado=0, counters=0. First cycle after release -> pop granted; estado=2 on the next edge.
- Routing/latency: VC0 holds 6'h05 then 6'h12, VC1 empty, no almost_full. Pop 6'h05 in cycle N -> D0_push=1, D0_data_out=6'h05 in N+1. Pop 6'h12 in N+1 -> D1_push=1, D1_data_out=6'h12 in N+2. contador_D0=1, contador_D1=1.
- Weighting (VC0_WEIGHT=3): both VCs continuously non-empty -> grant pattern VC0,VC0,VC0,VC1 repeating. wcnt returns to 0 after each VC1 grant.
- Fallback: VC0 head 6'h10 (dest D1) with D1_almost_full=1, VC1 head 6'h01 (dest D0) -> VC1_pop=1, VC0_pop=0. With both heads to D1 -> no pop, estado=3.
- Drain/idle: 4 words pushed, then both VCs empty -> estado=1, idle=1, pushes=0, data_outs hold the last values.
- Counter wrap: force 256 pushes to D0 -> contador_D0 returns to 0. Reset asserted during a pop -> the following push is suppressed.
